// File: rtl/dw02_sum_gather.sv
// Gathers a stream of operand words into one packed group that a
// num_inputs-operand summer can consume directly; short groups are zero-padded.
module dw02_sum_gather #(
    parameter int num_inputs  = 4,
    parameter int input_width = 32,
    localparam int CW         = $clog2(num_inputs + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [input_width-1:0]            in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [input_width*num_inputs-1:0] INPUT,
    output logic [CW-1:0]                     out_count
);

    localparam int SW = (num_inputs > 1) ? $clog2(num_inputs) : 1;
    localparam int BW = input_width * num_inputs;
    localparam logic [SW-1:0] LAST_SLOT = SW'(num_inputs - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_slot;
    logic [BW-1:0]   r_data;
    logic [CW-1:0]   r_count;

    state_t          w_nxt_state;
    logic [SW-1:0]   w_nxt_slot;
    logic [BW-1:0]   w_nxt_data;
    logic [CW-1:0]   w_nxt_count;
    logic            w_in_ready;
    logic            w_in_hs;
    logic            w_out_hs;

    // In HOLD the downstream accept frees the register this same cycle,
    // so the upstream may refill slot 0 without a bubble.
    assign w_in_ready = !rst && ((r_state == S_FILL) || out_ready);
    assign w_in_hs    = in_valid && w_in_ready;
    assign w_out_hs   = (r_state == S_HOLD) && out_ready;

    // NOTE: every always_comb output gets a default first; otherwise paths
    // that skip an assignment infer latches.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_slot  = r_slot;
        w_nxt_data  = r_data;
        w_nxt_count = r_count;

        case (r_state)
            S_FILL: begin
                if (w_in_hs) begin
                    for (int i = 0; i < num_inputs; i++) begin
                        if (r_slot == SW'(i)) begin
                            w_nxt_data[i*input_width +: input_width] = in_data;
                        end
                    end
                    if (in_last || (r_slot == LAST_SLOT)) begin
                        w_nxt_state = S_HOLD;
                        w_nxt_slot  = '0;
                        w_nxt_count = CW'(r_slot) + CW'(1);
                    end else begin
                        w_nxt_slot  = r_slot + 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (w_out_hs) begin
                    w_nxt_state = S_FILL;
                    w_nxt_slot  = '0;
                    w_nxt_data  = '0;
                    w_nxt_count = '0;
                    if (w_in_hs) begin
                        w_nxt_data[input_width-1:0] = in_data;
                        if (in_last) begin
                            w_nxt_state = S_HOLD;
                            w_nxt_count = CW'(1);
                        end else begin
                            w_nxt_slot  = SW'(1);
                        end
                    end
                end
            end

            default: begin
                w_nxt_state = S_FILL;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_slot  <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_slot  <= w_nxt_slot;
            r_data  <= w_nxt_data;
            r_count <= w_nxt_count;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_HOLD);
    assign INPUT     = r_data;
    assign out_count = r_count;

endmodule

// File: tb/tb_dw02_sum_gather.sv
// Directed bench for dw02_sum_gather with num_inputs=4, input_width=8.
module tb_dw02_sum_gather;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = $clog2(N + 1);

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [W*N-1:0]  INPUT;
    logic [CW-1:0]   out_count;

    int checks = 0;
    int errors = 0;

    dw02_sum_gather #(
        .num_inputs  (N),
        .input_width (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .INPUT     (INPUT),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_input",     INPUT,     0);
        check("rst_count",     out_count, 0);
        check("rst_in_ready",  in_ready,  0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Full group
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        check("full_no_early_valid", out_valid, 0);
        send(8'h04, 1'b0);
        idle();
        check("full_valid", out_valid, 1);
        check("full_input", INPUT, 32'h04030201);
        check("full_count", out_count, 4);
        step();
        check("full_consumed_valid", out_valid, 0);
        check("full_consumed_clear", INPUT, 0);

        // Short groups after a full one: stale slots must read zero
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        idle();
        check("short_valid", out_valid, 1);
        check("short_input", INPUT, 32'h00002211);
        check("short_count", out_count, 2);
        step();
        send(8'h33, 1'b1);
        idle();
        check("short1_input", INPUT, 32'h00000033);
        check("short1_count", out_count, 1);
        step();

        // Backpressure for 5 cycles with a word waiting upstream
        out_ready = 1'b0;
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        send(8'h44, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h99;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid",    out_valid, 1);
            check("bp_input",    INPUT,     32'h44434241);
            check("bp_in_ready", in_ready,  0);
            step();
        end
        check("bp_count", out_count, 4);
        idle();
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        step();
        check("bp_consumed_valid", out_valid, 0);
        check("bp_consumed_input", INPUT, 0);
        step();
        check("bp_consumed_once", out_valid, 0);

        // Streaming with no bubble across the group boundary
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            in_last  = 1'b0;
            #1;
            check("stream_in_ready", in_ready, 1);
            step();
            if (i == 4) begin
                check("stream_g0_valid", out_valid, 1);
                check("stream_g0_input", INPUT, 32'h04030201);
            end
            if (i == 5) begin
                check("stream_refill_valid", out_valid, 0);
                check("stream_refill_input", INPUT, 32'h00000005);
            end
            if (i == 8) begin
                check("stream_g1_valid", out_valid, 1);
                check("stream_g1_input", INPUT, 32'h08070605);
                check("stream_g1_count", out_count, 4);
            end
        end

        // Single-word group closed during pass-through
        send(8'h5A, 1'b1);
        idle();
        check("single_valid", out_valid, 1);
        check("single_input", INPUT, 32'h0000005A);
        check("single_count", out_count, 1);
        step();
        check("single_consumed", out_valid, 0);

        // Reset mid-group discards the partial group
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        idle();
        rst = 1'b1;
        step();
        check("midrst_valid",    out_valid, 0);
        check("midrst_input",    INPUT,     0);
        check("midrst_count",    out_count, 0);
        check("midrst_in_ready", in_ready,  0);
        rst = 1'b0;

        // in_last without in_valid is ignored
        in_valid = 1'b0;
        in_last  = 1'b1;
        step();
        check("idle_last_ignored", out_valid, 0);

        // Fresh group; in_last on the final slot acts as a full group
        send(8'h81, 1'b0);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b1);
        idle();
        check("fresh_valid", out_valid, 1);
        check("fresh_input", INPUT, 32'h84838281);
        check("fresh_count", out_count, 4);
        step();
        check("fresh_consumed", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
